// File: rtl/hazard1_shift_serial_if.sv
// Request/response handshake bundle between the execute stage and the iterative shifter.
interface hazard1_shift_serial_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_din;
    logic [4:0]  req_shamt;
    logic        req_right_nleft;
    logic        req_rotate;
    logic        req_arith;
    logic        kill;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_dout;

    modport master (
        output req_valid, req_din, req_shamt, req_right_nleft, req_rotate, req_arith,
        output kill, resp_ready,
        input  req_ready, resp_valid, resp_dout
    );

    modport slave (
        input  req_valid, req_din, req_shamt, req_right_nleft, req_rotate, req_arith,
        input  kill, resp_ready,
        output req_ready, resp_valid, resp_dout
    );
endinterface

// File: rtl/hazard1_shift_serial.sv
// Iterative SLL/SRL/SRA/ROL/ROR shifter: moves at most STEP bit positions per cycle
// until the requested distance is consumed, then holds the result until taken.
module hazard1_shift_serial #(
    parameter int STEP = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    hazard1_shift_serial_if.slave    bus
);
    localparam logic [4:0] STEP_W = 5'(STEP);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] acc_reg;
    logic [4:0]  rem_reg;
    logic        right_nleft_reg;
    logic        rotate_reg;
    logic        sext_reg;

    logic [4:0]  step_amt;
    logic [4:0]  rem_after;
    logic [31:0] shift_res;
    logic [31:0] shifted [1:STEP];

    assign step_amt  = (rem_reg < STEP_W) ? rem_reg : STEP_W;
    assign rem_after = rem_reg - step_amt;

    // One candidate per possible per-cycle distance; rotates recycle the bits pushed out.
    generate
        for (genvar gi = 1; gi <= STEP; gi++) begin : g_stage
            logic [gi-1:0] fill_right;
            logic [gi-1:0] fill_left;
            assign fill_right = rotate_reg ? acc_reg[gi-1:0] : {gi{sext_reg}};
            assign fill_left  = rotate_reg ? acc_reg[31:32-gi] : '0;
            assign shifted[gi] = right_nleft_reg ? {fill_right, acc_reg[31:gi]}
                                                 : {acc_reg[31-gi:0], fill_left};
        end
    endgenerate

    always_comb begin
        shift_res = acc_reg;
        for (int k = 1; k <= STEP; k++) begin
            if (step_amt == 5'(k)) begin
                shift_res = shifted[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (bus.kill) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (bus.req_valid) state_next = (bus.req_shamt != 5'd0) ? BUSY : DONE;
                BUSY: if (rem_after == 5'd0) state_next = DONE;
                DONE: if (bus.resp_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath holds its value on kill so a flushed result is simply never presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg         <= '0;
            rem_reg         <= '0;
            right_nleft_reg <= 1'b0;
            rotate_reg      <= 1'b0;
            sext_reg        <= 1'b0;
        end else if (!bus.kill) begin
            if (state_reg == IDLE && bus.req_valid) begin
                acc_reg         <= bus.req_din;
                rem_reg         <= bus.req_shamt;
                right_nleft_reg <= bus.req_right_nleft;
                rotate_reg      <= bus.req_rotate;
                sext_reg        <= bus.req_arith && !bus.req_rotate && bus.req_right_nleft
                                   && bus.req_din[31];
            end else if (state_reg == BUSY) begin
                acc_reg <= shift_res;
                rem_reg <= rem_after;
            end
        end
    end

    assign bus.req_ready  = (state_reg == IDLE);
    assign bus.resp_valid = (state_reg == DONE);
    assign bus.resp_dout  = acc_reg;
endmodule

// File: tb/tb_hazard1_shift_serial.sv
// Drives one shifter per legal STEP (1,2,4,8,16) and compares results and timing
// against an arithmetic model of the five shift operations.
module tb_hazard1_shift_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]        req_valid_v  = '0;
    logic [4:0]        resp_ready_v = '0;
    logic [4:0]        kill_v       = '0;
    logic [4:0]        req_ready_v;
    logic [4:0]        resp_valid_v;
    logic [4:0][31:0]  resp_dout_v;
    logic [31:0]       din = '0;
    logic [4:0]        shamt = '0;
    logic              right_nleft = 1'b0;
    logic              rotate = 1'b0;
    logic              arith = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_dut
            hazard1_shift_serial_if bus ();
            assign bus.req_valid       = req_valid_v[gi];
            assign bus.req_din         = din;
            assign bus.req_shamt       = shamt;
            assign bus.req_right_nleft = right_nleft;
            assign bus.req_rotate      = rotate;
            assign bus.req_arith       = arith;
            assign bus.kill            = kill_v[gi];
            assign bus.resp_ready      = resp_ready_v[gi];
            assign req_ready_v[gi]     = bus.req_ready;
            assign resp_valid_v[gi]    = bus.resp_valid;
            assign resp_dout_v[gi]     = bus.resp_dout;

            hazard1_shift_serial #(.STEP(1 << gi)) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus.slave)
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh,
                                              input bit rn, input bit rot, input bit ar);
        if (rot) begin
            if (sh == 0) return d;
            return rn ? ((d >> sh) | (d << (32 - sh))) : ((d << sh) | (d >> (32 - sh)));
        end
        if (!rn) return d << sh;
        if (ar)  return 32'($signed(d) >>> sh);
        return d >> sh;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int idx, input logic [31:0] d, input logic [4:0] sh,
                            input bit rn, input bit rot, input bit ar);
        din = d; shamt = sh; right_nleft = rn; rotate = rot; arith = ar;
        req_valid_v[idx] = 1'b1;
        check("req_ready_before_accept", 32'(req_ready_v[idx]), 32'd1);
        tick();
        req_valid_v[idx] = 1'b0;
    endtask

    // Full transaction: accept, latency, result, stall stability and handshake.
    task automatic do_op(input string tag, input int idx, input logic [31:0] d,
                         input logic [4:0] sh, input bit rn, input bit rot, input bit ar,
                         input logic [31:0] exp, input int stall);
        int lat;
        int step;
        step = 1 << idx;
        start_op(idx, d, sh, rn, rot, ar);
        lat = 1;
        while (!resp_valid_v[idx] && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(1 + (int'(sh) + step - 1) / step));
        check({tag, "_dout"}, resp_dout_v[idx], exp);
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_stall_dout"}, resp_dout_v[idx], exp);
            check({tag, "_stall_valid"}, 32'(resp_valid_v[idx]), 32'd1);
            check({tag, "_stall_req_ready"}, 32'(req_ready_v[idx]), 32'd0);
        end
        resp_ready_v[idx] = 1'b1;
        tick();
        resp_ready_v[idx] = 1'b0;
        check({tag, "_resp_drop"}, 32'(resp_valid_v[idx]), 32'd0);
        check({tag, "_idle_ready"}, 32'(req_ready_v[idx]), 32'd1);
        $display("op %s step=%0d din=%h shamt=%0d rn=%0d rot=%0d ar=%0d dout=%h lat=%0d",
                 tag, step, d, sh, rn, rot, ar, exp, lat);
    endtask

    initial begin
        int seen;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            check("reset_req_ready", 32'(req_ready_v[i]), 32'd1);
            check("reset_resp_valid", 32'(resp_valid_v[i]), 32'd0);
            check("reset_resp_dout", resp_dout_v[i], 32'd0);
        end
        rst = 1'b0;
        tick();

        do_op("sra31", 0, 32'h8000_0000, 5'd31, 1, 0, 1, 32'hFFFF_FFFF, 0);
        do_op("srl31", 0, 32'h8000_0000, 5'd31, 1, 0, 0, 32'h0000_0001, 0);
        do_op("sll0",  0, 32'h0000_0001, 5'd0,  0, 0, 0, 32'h0000_0001, 1);
        do_op("ror1",  0, 32'h0000_0001, 5'd1,  1, 1, 0, 32'h8000_0000, 0);
        do_op("rol4",  0, 32'h8000_0000, 5'd4,  0, 1, 0, 32'h0000_0008, 0);
        do_op("ror4a", 0, 32'h8000_0001, 5'd4,  1, 1, 1, 32'h1800_0000, 0);
        do_op("srl5s4", 2, 32'hF000_0000, 5'd5, 1, 0, 0, 32'h0780_0000, 5);

        // Kill mid-shift: no response ever, then a clean follow-up.
        start_op(0, 32'h1234_5678, 5'd20, 1, 0, 0);
        repeat (3) tick();
        kill_v[0] = 1'b1;
        tick();
        kill_v[0] = 1'b0;
        check("kill_busy_ready", 32'(req_ready_v[0]), 32'd1);
        check("kill_busy_valid", 32'(resp_valid_v[0]), 32'd0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (resp_valid_v[0]) seen++;
        end
        check("kill_busy_no_resp", 32'(seen), 32'd0);
        do_op("after_kill", 0, 32'h1234_5678, 5'd20, 0, 0, 0, 32'h6780_0000, 0);

        // Kill in IDLE beats a simultaneous request.
        din = 32'hCAFE_F00D; shamt = 5'd0;
        req_valid_v[1] = 1'b1;
        kill_v[1] = 1'b1;
        tick();
        req_valid_v[1] = 1'b0;
        kill_v[1] = 1'b0;
        check("kill_idle_ready", 32'(req_ready_v[1]), 32'd1);
        check("kill_idle_valid", 32'(resp_valid_v[1]), 32'd0);
        tick();
        check("kill_idle_valid2", 32'(resp_valid_v[1]), 32'd0);

        // Kill in DONE with resp_ready high still returns to IDLE.
        start_op(3, 32'h0000_00F0, 5'd3, 0, 0, 0);
        while (!resp_valid_v[3]) tick();
        kill_v[3] = 1'b1;
        resp_ready_v[3] = 1'b1;
        tick();
        kill_v[3] = 1'b0;
        resp_ready_v[3] = 1'b0;
        check("kill_done_ready", 32'(req_ready_v[3]), 32'd1);
        check("kill_done_valid", 32'(resp_valid_v[3]), 32'd0);

        // Asynchronous reset mid-shift.
        start_op(1, 32'hDEAD_BEEF, 5'd31, 0, 1, 0);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("rst_async_ready", 32'(req_ready_v[1]), 32'd1);
        check("rst_async_valid", 32'(resp_valid_v[1]), 32'd0);
        check("rst_async_dout", resp_dout_v[1], 32'd0);
        tick();
        rst = 1'b0;
        tick();

        for (int n = 0; n < 150; n++) begin
            int idx, op, stall;
            logic [31:0] d;
            logic [4:0] sh;
            bit rn, rot, ar;
            idx = $urandom_range(0, 4);
            op = $urandom_range(0, 4);
            d = $urandom;
            sh = 5'($urandom_range(0, 31));
            stall = $urandom_range(0, 3);
            rot = (op >= 3);
            rn = (op == 1 || op == 2 || op == 4);
            ar = (op == 2) ? 1'b1 : 1'($urandom_range(0, 1)) && (op != 1);
            do_op("rand", idx, d, sh, rn, rot, ar, ref_shift(d, int'(sh), rn, rot, ar), stall);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hazard1_shift_serial.md
# hazard1_shift_serial

Multi-cycle iterative shifter for area-constrained Hazard1 configurations. It performs the same five operations as the single-cycle barrel shifter: SLL, SRL, SRA, ROL and ROR. It does so over several cycles using a small STEP-bit shift stage. It sits in the execute stage behind a valid/ready request/response handshake, and the core stalls on it while a shift is in flight.

## Interface
- STEP, default 1: maximum shift distance per cycle. Legal values are 1, 2, 4, 8 and 16.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request. High only in IDLE.
- req_din  input  32  operand.
- req_shamt  input  5  shift amount.
- req_right_nleft  input  1  1 = shift/rotate right, 0 = left.
- req_rotate  input  1  1 = rotate (bits wrap around).
- req_arith  input  1  sign-fill on right shift. Ignored when rotating or shifting left.
- kill  input  1  abandon any in-flight operation.
- resp_valid  output  1  result present.
- resp_ready  input  1  consumer accepts result.
- resp_dout  output  32  result, registered.

## Operation
- State is held in a 3-state machine, plus accumulator acc[31:0], remaining-count rem[4:0], and latched right_nleft, rotate and sext.
- sext = arith && !rotate && right_nleft && din[31].
- IDLE:
  - req_ready=1.
  - On req_valid: latch operands, acc<=req_din, rem<=req_shamt.
  - Go to BUSY if req_shamt!=0, else DONE.
- BUSY, each cycle:
  - s = min(rem, STEP).
  - Shift acc by s in the latched direction.
    - Logical: fill with zeros.
    - Arithmetic right: fill with sext.
    - Rotate: vacated bits take the bits shifted out.
  - rem <= rem - s.
  - Go to DONE when rem - s == 0.
- DONE:
  - resp_valid=1 and resp_dout=acc, both held stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE.
- Result must equal the barrel-shifter result for identical inputs, for every shamt 0..31 and every op.
- Arithmetic is modulo 32 bits. rem never underflows because s<=rem.
- kill:
  - In any state, the next state is IDLE, resp_valid drops the following cycle, and acc is not cleared.
  - kill in IDLE with req_valid high: the request is dropped, and kill has priority.
  - kill in DONE: the result is discarded, even if resp_ready is high in the same cycle. The handshake is still deemed complete for the consumer, which must treat kill as a flush.
- No new request is accepted while in BUSY or DONE. There is no request/response overlap.
- rst mid-operation: immediate return to IDLE, with all state at reset values.

## Timing
- Reset values: state=IDLE, req_ready=1 (decoded from state), resp_valid=0, resp_dout=0, acc=0, rem=0.
- Accept happens on the edge where req_valid && req_ready. Call that cycle N.
- resp_valid first high in cycle N+1+ceil(shamt/STEP).
  - shamt=0 gives N+1.
  - STEP=1, shamt=31 gives N+32.
- Back-to-back throughput: the next accept is at earliest the cycle after the response handshake, because req_ready rises once back in IDLE.
- req_ready and resp_valid are pure state decodes, with no combinational path from any input.
- resp_dout changes only on accept or during BUSY. It is stable throughout DONE.

## Test plan
- STEP=1, SRA, din=0x80000000, shamt=31 -> resp_dout=0xFFFFFFFF, resp_valid first high 32 cycles after accept. Same stimulus as SRL -> 0x00000001.
- SLL, din=0x00000001, shamt=0 -> resp_dout=0x00000001 one cycle after accept, with BUSY never entered.
- Rotate:
  - ROR, din=0x00000001, shamt=1 -> 0x80000000.
  - ROL, din=0x80000000, shamt=4 -> 0x00000008.
  - ROR with arith=1, din=0x80000001, shamt=4 -> 0x18000000, with no sign fill.
- STEP=4, SRL, din=0xF0000000, shamt=5 -> exactly 2 BUSY cycles, resp_dout=0x07800000. Hold resp_ready low for 5 cycles -> resp_dout and resp_valid stable, req_ready=0 throughout.
- Abort paths:
  - Assert kill during BUSY of a shamt=20 shift -> IDLE next cycle, resp_valid never asserted. A following request completes correctly.
  - Assert rst mid-shift -> all outputs at reset values asynchronously.
- Randomised check against the barrel-shifter model: all ops, shamt 0..31, all STEP values, random resp_ready stalls -> zero mismatches.
